alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares the single 8-bit ALU between two requesters (port 0: instruction pipeline, port 1: auxiliary sequencer such as a multi-step address/shift helper) under round-robin arbitration. Accepts one operation at a time via valid/ready handshake, drives registered operands/select into the ALU, waits a per-opcode settle time, captures RESULT/ZERO and returns them to the granted requester with a one-cycle response pulse. Sits between the requesters and the ALU instance; the ALU itself is unchanged.

Parameters:
SETTLE_CYCLES, 2, clock cycles to wait after issue for SELECT 0,1,2,3,5,6,7,8 (legal 1..15)
MULT_CYCLES, 3, clock cycles to wait after issue for SELECT 4'b0100 mult (legal 1..15)

Ports:
CLK  input  1  rising-edge clock
RESET  input  1  asynchronous, active-low reset (0 = reset)
REQ_VALID  input  2  per-port request valid, bit i = port i
REQ_READY  output  2  per-port accept; at most one bit high
REQ_DATA1_0 / REQ_DATA1_1  input  8 each  operand DATA1 per port
REQ_DATA2_0 / REQ_DATA2_1  input  8 each  operand DATA2 per port
REQ_SELECT_0 / REQ_SELECT_1  input  4 each  ALU opcode per port
RSP_VALID  output  2  per-port one-cycle response pulse
RSP_RESULT  output  8  captured ALU result (shared; qualified by RSP_VALID)
RSP_ZERO  output  1  captured ALU ZERO flag
RSP_ERR  output  1  1 = illegal SELECT (>4'b1000), no ALU op performed
ALU_DATA1  output  8  registered operand to ALU DATA1
ALU_DATA2  output  8  registered operand to ALU DATA2
ALU_SELECT  output  4  registered opcode to ALU SELECT
ALU_RESULT  input  8  from ALU RESULT
ALU_ZERO  input  1  from ALU ZERO
BUSY  output  1  1 whenever state != IDLE

Behaviour:
- Reset (RESET=0, async): state IDLE; ALU_DATA1/ALU_DATA2/ALU_SELECT=0; RSP_VALID=0, RSP_RESULT=0, RSP_ZERO=0, RSP_ERR=0; count=0; LAST_GRANT=1 (port 0 wins first tie); BUSY=0. Op in flight at reset is discarded; no response is ever issued for it.
- FSM states: IDLE, BUSY, DONE.
- IDLE: REQ_READY combinational. One valid -> that port granted. Both valid -> port != LAST_GRANT granted. REQ_READY[g]=1 only in IDLE.
- Handshake at edge k (REQ_VALID[g]&REQ_READY[g]): latch port g operands/select into ALU_* regs, store g, LAST_GRANT<=g.
  - SELECT legal: count<=MULT_CYCLES if SELECT==4'b0100 else SETTLE_CYCLES; ->BUSY.
  - SELECT >4'b1000: ALU_* still loaded; ->DONE directly with RSP_ERR<=1, RSP_RESULT<=0, RSP_ZERO<=0.
- BUSY: ALU_* held stable. count decrements each edge; at edge where count==1: RSP_RESULT<=ALU_RESULT, RSP_ZERO<=ALU_ZERO, RSP_ERR<=0, ->DONE. BUSY lasts exactly N cycles (N = loaded count).
- DONE: RSP_VALID[g]=1 for exactly this one cycle (other bit 0); ->IDLE next edge. RSP_RESULT/ZERO/ERR hold last values until next capture.
- Latency: handshake edge k -> RSP_VALID high in cycle after edge k+N; illegal op: cycle after edge k. Next handshake earliest at edge k+N+2 (legal) / k+2 (illegal).
- Requester obligation: hold REQ_* stable while REQ_VALID=1 and not accepted; arbiter never drops an unaccepted request. Deasserting REQ_VALID before acceptance is a legal withdrawal.
- No new request accepted in BUSY or DONE, even if the other port is valid; waiting port is granted next IDLE by round-robin.
- Count is 4-bit; parameters outside 1..15 are illegal (elaboration check).

Test Plan:
- Single add, port 0: DATA1=8'd5, DATA2=8'd3, SELECT=4'b0001 -> REQ_READY[0] high in IDLE; ALU_SELECT=1 for 2 cycles; RSP_VALID=2'b01 for 1 cycle, RSP_RESULT=8'd8, RSP_ZERO=0, RSP_ERR=0.
- Mult latency, port 1: DATA1=8'hFE (-2), DATA2=8'd3, SELECT=4'b0100 -> BUSY 3 cycles; RSP_VALID=2'b10, RSP_RESULT=8'hFA.
- Contention: both ports valid from reset, port 0 and(8'hF0,8'h0F), port 1 loadi 8'h00 -> port 0 served first (RSP_ZERO=1, RESULT 0), then port 1 (RESULT 0, ZERO=1); REQ_READY never 2'b11; third back-to-back pair grants port 0 again.
- Illegal op: SELECT=4'b1010 on port 0 -> RSP_VALID=2'b01 in cycle after handshake edge, RSP_ERR=1, RSP_RESULT=0; BUSY state never entered.
- Reset mid-op: assert RESET=0 during BUSY of a mult -> all outputs 0 immediately (async); after release no RSP_VALID for discarded op; next port 0 request served normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Round-robin front end that shares one 8-bit ALU between two requesters.
//   Port 0 is the instruction pipeline and port 1 is an auxiliary sequencer.
//   One operation is in flight at a time. The operands and opcode are
//   registered into the ALU. The block waits a per-opcode settle time, then
//   captures RESULT/ZERO and returns them to the granted port with a
//   single-cycle response pulse.
//
// Ports
//   CLK, RESET          rising-edge clock, asynchronous active-low reset
//   REQ_VALID/READY     per-port request handshake (bit i = port i)
//   REQ_DATA1_x/DATA2_x per-port operands
//   REQ_SELECT_x        per-port ALU opcode
//   RSP_VALID           per-port one-cycle response pulse
//   RSP_RESULT/ZERO/ERR shared captured response, qualified by RSP_VALID
//   ALU_DATA1/2/SELECT  registered drive into the ALU
//   ALU_RESULT/ZERO     combinational return from the ALU
//   BUSY                high whenever an operation is in progress

module alu_arbiter #(
  parameter int SETTLE_CYCLES = 2,
  parameter int MULT_CYCLES   = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] REQ_VALID,
  output logic [1:0] REQ_READY,
  input  logic [7:0] REQ_DATA1_0,
  input  logic [7:0] REQ_DATA1_1,
  input  logic [7:0] REQ_DATA2_0,
  input  logic [7:0] REQ_DATA2_1,
  input  logic [3:0] REQ_SELECT_0,
  input  logic [3:0] REQ_SELECT_1,
  output logic [1:0] RSP_VALID,
  output logic [7:0] RSP_RESULT,
  output logic       RSP_ZERO,
  output logic       RSP_ERR,
  output logic [7:0] ALU_DATA1,
  output logic [7:0] ALU_DATA2,
  output logic [3:0] ALU_SELECT,
  input  logic [7:0] ALU_RESULT,
  input  logic       ALU_ZERO,
  output logic       BUSY
);

  // The settle counter is only 4 bits wide. Reject any wait time it cannot hold.
  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("alu_arbiter: SETTLE_CYCLES must be in 1..15");
    end
    if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : g_bad_mult
      $error("alu_arbiter: MULT_CYCLES must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] SETTLE_C = 4'(SETTLE_CYCLES);
  localparam logic [3:0] MULT_C   = 4'(MULT_CYCLES);
  localparam logic [3:0] SEL_MULT = 4'b0100;
  localparam logic [3:0] SEL_MAX  = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] alu_data1_q, alu_data1_d;
  logic [7:0] alu_data2_q, alu_data2_d;
  logic [3:0] alu_select_q, alu_select_d;
  logic [3:0] count_q, count_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] rsp_result_q, rsp_result_d;
  logic       rsp_zero_q, rsp_zero_d;
  logic       rsp_err_q, rsp_err_d;

  // Arbitration. A port is only granted when it is valid. Because READY
  // is returned only to a valid port, a grant here is also a handshake.
  logic       gnt_any;
  logic       gnt_port;
  logic [7:0] mux_data1;
  logic [7:0] mux_data2;
  logic [3:0] mux_select;
  logic       sel_illegal;

  always_comb begin
    gnt_any  = 1'b0;
    gnt_port = 1'b0;
    if (state_q == S_IDLE) begin
      case (REQ_VALID)
        2'b01:   begin gnt_any = 1'b1; gnt_port = 1'b0;          end
        2'b10:   begin gnt_any = 1'b1; gnt_port = 1'b1;          end
        2'b11:   begin gnt_any = 1'b1; gnt_port = ~last_grant_q; end
        default: begin gnt_any = 1'b0; gnt_port = 1'b0;          end
      endcase
    end
  end

  assign mux_data1   = gnt_port ? REQ_DATA1_1  : REQ_DATA1_0;
  assign mux_data2   = gnt_port ? REQ_DATA2_1  : REQ_DATA2_0;
  assign mux_select  = gnt_port ? REQ_SELECT_1 : REQ_SELECT_0;
  assign sel_illegal = (mux_select > SEL_MAX);

  // FSM: state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          // An illegal opcode skips the ALU wait and reports an error at once.
          state_d = sel_illegal ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (count_q == 4'd1) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      always_comb begin
        REQ_READY[gi] = gnt_any && (gnt_port == 1'(gi));
        RSP_VALID[gi] = (state_q == S_DONE) && (grant_q == 1'(gi));
      end
    end
  endgenerate

  assign BUSY = (state_q != S_IDLE);

  // Datapath next-state
  always_comb begin
    alu_data1_d  = alu_data1_q;
    alu_data2_d  = alu_data2_q;
    alu_select_d = alu_select_q;
    count_d      = count_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          alu_data1_d  = mux_data1;
          alu_data2_d  = mux_data2;
          alu_select_d = mux_select;
          grant_d      = gnt_port;
          last_grant_d = gnt_port;
          if (sel_illegal) begin
            rsp_result_d = 8'd0;
            rsp_zero_d   = 1'b0;
            rsp_err_d    = 1'b1;
          end else begin
            count_d = (mux_select == SEL_MULT) ? MULT_C : SETTLE_C;
          end
        end
      end
      S_BUSY: begin
        count_d = count_q - 4'd1;
        // The ALU has had count cycles to settle on the held operands.
        if (count_q == 4'd1) begin
          rsp_result_d = ALU_RESULT;
          rsp_zero_d   = ALU_ZERO;
          rsp_err_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers. LAST_GRANT resets to 1 so that port 0 wins the first tie.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      alu_data1_q  <= 8'd0;
      alu_data2_q  <= 8'd0;
      alu_select_q <= 4'd0;
      count_q      <= 4'd0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_result_q <= 8'd0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      alu_data1_q  <= alu_data1_d;
      alu_data2_q  <= alu_data2_d;
      alu_select_q <= alu_select_d;
      count_q      <= count_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign ALU_DATA1  = alu_data1_q;
  assign ALU_DATA2  = alu_data2_q;
  assign ALU_SELECT = alu_select_q;
  assign RSP_RESULT = rsp_result_q;
  assign RSP_ZERO   = rsp_zero_q;
  assign RSP_ERR    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Directed bench for alu_arbiter. The bench contains a small combinational
//   ALU model with these opcodes:
//     0 = load DATA2, 1 = add, 2 = sub, 3 = and, 4 = mult (low byte),
//     5 = or, 6 = xor, 7 = shl, 8 = shr.
//   Each transaction prints one line. Expected values are hand-computed.

module tb_alu_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_data1_0, req_data1_1, req_data2_0, req_data2_1;
  logic [3:0] req_select_0, req_select_1;
  logic [1:0] rsp_valid;
  logic [7:0] rsp_result;
  logic       rsp_zero, rsp_err;
  logic [7:0] alu_data1, alu_data2;
  logic [3:0] alu_select;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       busy;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.SETTLE_CYCLES(2), .MULT_CYCLES(3)) dut (
    .CLK          (clk),
    .RESET        (rst_n),
    .REQ_VALID    (req_valid),
    .REQ_READY    (req_ready),
    .REQ_DATA1_0  (req_data1_0),
    .REQ_DATA1_1  (req_data1_1),
    .REQ_DATA2_0  (req_data2_0),
    .REQ_DATA2_1  (req_data2_1),
    .REQ_SELECT_0 (req_select_0),
    .REQ_SELECT_1 (req_select_1),
    .RSP_VALID    (rsp_valid),
    .RSP_RESULT   (rsp_result),
    .RSP_ZERO     (rsp_zero),
    .RSP_ERR      (rsp_err),
    .ALU_DATA1    (alu_data1),
    .ALU_DATA2    (alu_data2),
    .ALU_SELECT   (alu_select),
    .ALU_RESULT   (alu_result),
    .ALU_ZERO     (alu_zero),
    .BUSY         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU model
  logic [15:0] prod;
  always_comb begin
    prod = 16'(alu_data1) * 16'(alu_data2);
    case (alu_select)
      4'd0:    alu_result = alu_data2;
      4'd1:    alu_result = alu_data1 + alu_data2;
      4'd2:    alu_result = alu_data1 - alu_data2;
      4'd3:    alu_result = alu_data1 & alu_data2;
      4'd4:    alu_result = prod[7:0];
      4'd5:    alu_result = alu_data1 | alu_data2;
      4'd6:    alu_result = alu_data1 ^ alu_data2;
      4'd7:    alu_result = alu_data1 << 1;
      4'd8:    alu_result = alu_data1 >> 1;
      default: alu_result = 8'hAA;
    endcase
    alu_zero = (alu_result == 8'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Presents a request on one port (called at a negedge while the DUT is
  // in IDLE). It waits for the handshake, then for the response, and
  // finally steps into the following IDLE cycle.
  task automatic issue(input int port, input logic [7:0] d1, input logic [7:0] d2,
                       input logic [3:0] sel, input logic [7:0] exp_res,
                       input logic exp_zero, input logic exp_err, input int exp_wait);
    int  n;
    bit  leak;
    bit  seen;
    n    = 0;
    leak = 1'b0;
    seen = 1'b0;
    if (port == 0) begin
      req_data1_0 = d1; req_data2_0 = d2; req_select_0 = sel; req_valid[0] = 1'b1;
    end else begin
      req_data1_1 = d1; req_data2_1 = d2; req_select_1 = sel; req_valid[1] = 1'b1;
    end
    #1;
    check("req_ready", 32'(req_ready), 32'(2'b01 << port));
    @(posedge clk);
    @(negedge clk);
    req_valid[port] = 1'b0;
    check("alu_select", 32'(alu_select), 32'(sel));
    check("alu_data1",  32'(alu_data1),  32'(d1));
    check("alu_data2",  32'(alu_data2),  32'(d2));
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid != 2'b00) begin
        seen = 1'b1;
        break;
      end
      if (req_ready != 2'b00) leak = 1'b1;
      if (alu_select != sel) leak = 1'b1;
      n++;
      @(negedge clk);
    end
    check("rsp_seen",   32'(seen), 32'd1);
    check("wait_cycles", 32'(n), 32'(exp_wait));
    check("busy_hold",  32'(leak), 32'd0);
    check("rsp_valid",  32'(rsp_valid), 32'(2'b01 << port));
    check("rsp_result", 32'(rsp_result), 32'(exp_res));
    check("rsp_zero",   32'(rsp_zero), 32'(exp_zero));
    check("rsp_err",    32'(rsp_err), 32'(exp_err));
    check("done_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("pulse_end",  32'(rsp_valid), 32'd0);
    check("idle_busy",  32'(busy), 32'd0);
    $display("txn port=%0d sel=%0h d1=%0h d2=%0h -> res=%0h zero=%0b err=%0b wait=%0d",
             port, sel, d1, d2, rsp_result, rsp_zero, rsp_err, n);
  endtask

  initial begin
    bit stray;
    rst_n        = 1'b0;
    req_valid    = 2'b00;
    req_data1_0  = 8'd0; req_data2_0 = 8'd0; req_select_0 = 4'd0;
    req_data1_1  = 8'd0; req_data2_1 = 8'd0; req_select_1 = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_rspv",   32'(rsp_valid), 32'd0);
    check("rst_alusel", 32'(alu_select), 32'd0);
    check("rst_result", 32'(rsp_result), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention from reset. Port 0 wins the first tie, and port 1 waits.
    req_data1_1 = 8'h00; req_data2_1 = 8'h00; req_select_1 = 4'd0; req_valid[1] = 1'b1;
    issue(0, 8'hF0, 8'h0F, 4'd3, 8'h00, 1'b1, 1'b0, 2);
    issue(1, 8'h00, 8'h00, 4'd0, 8'h00, 1'b1, 1'b0, 2);
    // A third pair arrives back-to-back, and port 0 is granted again.
    req_valid[1] = 1'b1; req_data2_1 = 8'h11;
    issue(0, 8'h12, 8'h34, 4'd1, 8'h46, 1'b0, 1'b0, 2);
    issue(1, 8'h00, 8'h11, 4'd0, 8'h11, 1'b0, 1'b0, 2);

    // An illegal opcode responds on the cycle after the handshake.
    issue(0, 8'h77, 8'h66, 4'b1010, 8'h00, 1'b0, 1'b1, 0);
    // A single add on port 0 clears the error flag.
    issue(0, 8'd5, 8'd3, 4'd1, 8'd8, 1'b0, 1'b0, 2);
    // A mult on port 1 uses the long settle time.
    issue(1, 8'hFE, 8'd3, 4'd4, 8'hFA, 1'b0, 1'b0, 3);

    // Reset is asserted in the middle of a mult. The op is discarded.
    req_data1_0 = 8'd7; req_data2_0 = 8'd9; req_select_0 = 4'd4; req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_busy",   32'(busy), 32'd0);
    check("async_alusel", 32'(alu_select), 32'd0);
    check("async_alud1",  32'(alu_data1), 32'd0);
    check("async_result", 32'(rsp_result), 32'd0);
    check("async_rspv",   32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00 || busy) stray = 1'b1;
    end
    check("no_stray_rsp", 32'(stray), 32'd0);
    $display("txn reset mid-op discarded stray=%0b", stray);
    issue(0, 8'd5, 8'd3, 4'd1, 8'd8, 1'b0, 1'b0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a hung handshake so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  // Ready must never be returned to both ports at once.
  always @(negedge clk) begin
    if (req_ready == 2'b11) begin
      bad++;
      total++;
      $display("FAIL ready_onehot: got=%0b expected=not 11", req_ready);
    end
  end

endmodule
